// File: rtl/ppu_palette.sv
// PPU palette stage: 32x6 palette RAM with hardware backdrop mirroring and a CPU window.
// The render lookup takes two stages. Define PPU_PAL_GREYSCALE_EN to honour PPUMASK greyscale.
module ppu_palette (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] pixel,
  input  logic [9:0] x_idx,
  input  logic [9:0] scanline,
  input  logic       rendering_en,
  input  logic       greyscale,
  input  logic       pal_we,
  input  logic       pal_re,
  input  logic [4:0] pal_addr,
  input  logic [7:0] pal_data_in,
  output logic [7:0] pal_data_out,
  output logic [5:0] color_idx,
  output logic       color_valid
);
  localparam int STAGES = 2;

  logic [5:0]        ram [32];
  logic [4:0]        s1_addr;
  logic [STAGES:1]   vld_pipe;
  logic              visible;
  logic [4:0]        lookup_addr;
  logic [4:0]        cpu_addr;

  // Sprite entries x0/x4/x8/xC alias the background entries.
  function automatic logic [4:0] mirror(input logic [4:0] a);
    return (a[4] && (a[1:0] == 2'b00)) ? {1'b0, a[3:0]} : a;
  endfunction

  assign visible     = (x_idx < 10'd256) && (scanline < 10'd240);
  assign lookup_addr = (visible && rendering_en && (pixel[1:0] != 2'b00)) ? mirror(pixel) : 5'h00;
  assign cpu_addr    = mirror(pal_addr);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) ram[i] <= '0;
    end else if (pal_we) begin
      ram[cpu_addr] <= pal_data_in[5:0];
    end
  end

  // RAM reads below see pre-edge contents, giving read-before-write on collisions.
  always_ff @(posedge clk) begin
    if (reset) begin
      pal_data_out <= '0;
    end else if (pal_re) begin
      pal_data_out <= {2'b00, ram[cpu_addr]};
    end
  end

`ifdef PPU_PAL_GREYSCALE_EN
  logic [5:0] grey_mask;
  assign grey_mask = greyscale ? 6'h30 : 6'h3F;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_addr   <= '0;
      vld_pipe  <= '0;
      color_idx <= '0;
    end else begin
      s1_addr   <= lookup_addr;
      vld_pipe  <= {vld_pipe[STAGES-1:1], visible};
`ifdef PPU_PAL_GREYSCALE_EN
      color_idx <= ram[s1_addr] & grey_mask;
`else
      color_idx <= ram[s1_addr];
`endif
    end
  end

  assign color_valid = vld_pipe[STAGES];

`ifdef PPU_PAL_GREYSCALE_EN
  logic unused_ok;
  assign unused_ok = &{1'b0, pal_data_in[7:6]};
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, pal_data_in[7:6], greyscale};
`endif

endmodule

// File: tb/tb_ppu_palette.sv
// Directed bench for ppu_palette: a vector table for CPU access and lookups, plus
// hand-written sequences for a full-scanline sweep and a reset asserted mid-frame.
module tb_ppu_palette;
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] pixel;
  logic [9:0] x_idx, scanline;
  logic       rendering_en, greyscale, pal_we, pal_re;
  logic [4:0] pal_addr;
  logic [7:0] pal_data_in;
  logic [7:0] pal_data_out;
  logic [5:0] color_idx;
  logic       color_valid;

  int checks = 0;
  int failures = 0;

`ifdef PPU_PAL_GREYSCALE_EN
  localparam logic [5:0] GREY_M = 6'h30;
`else
  localparam logic [5:0] GREY_M = 6'h3F;
`endif

  ppu_palette dut (
    .clk(clk), .reset(reset), .pixel(pixel), .x_idx(x_idx), .scanline(scanline),
    .rendering_en(rendering_en), .greyscale(greyscale), .pal_we(pal_we), .pal_re(pal_re),
    .pal_addr(pal_addr), .pal_data_in(pal_data_in), .pal_data_out(pal_data_out),
    .color_idx(color_idx), .color_valid(color_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we, re;
    logic [4:0] addr;
    logic [7:0] din;
    logic [4:0] pix;
    logic [9:0] x, y;
    logic       ren, grey;
    logic       chk_c;
    logic [5:0] exp_c;
    logic       exp_v;
    logic       chk_d;
    logic [7:0] exp_d;
  } vec_t;

  localparam int NV = 26;
  vec_t tbl [NV];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    pal_we = v.we; pal_re = v.re; pal_addr = v.addr; pal_data_in = v.din;
    pixel = v.pix; x_idx = v.x; scanline = v.y; rendering_en = v.ren; greyscale = v.grey;
  endtask

  task automatic idle();
    pal_we = 1'b0; pal_re = 1'b0; pal_addr = '0; pal_data_in = '0;
    pixel = '0; x_idx = 10'd300; scanline = 10'd100; rendering_en = 1'b1; greyscale = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    int first_v, last_v, cnt_v;
    //        we    re    addr   din    pix    x        y        ren   grey  chk_c exp_c          v     chk_d exp_d
    tbl[0]  = '{1'b1, 1'b0, 5'h10, 8'hEA, 5'h00, 10'd300, 10'd100, 1'b1, 1'b0, 1'b1, 6'h2A,          1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 1'b1, 5'h00, 8'h00, 5'h00, 10'd300, 10'd100, 1'b1, 1'b0, 1'b0, 6'h00,          1'b0, 1'b1, 8'h2A};
    tbl[2]  = '{1'b0, 1'b1, 5'h10, 8'h00, 5'h00, 10'd300, 10'd100, 1'b1, 1'b0, 1'b0, 6'h00,          1'b0, 1'b1, 8'h2A};
    tbl[3]  = '{1'b1, 1'b0, 5'h01, 8'h33, 5'h00, 10'd300, 10'd100, 1'b1, 1'b0, 1'b0, 6'h00,          1'b0, 1'b0, 8'h00};
    tbl[4]  = '{1'b1, 1'b0, 5'h11, 8'h15, 5'h00, 10'd300, 10'd100, 1'b1, 1'b0, 1'b0, 6'h00,          1'b0, 1'b0, 8'h00};
    tbl[5]  = '{1'b0, 1'b1, 5'h01, 8'h00, 5'h00, 10'd300, 10'd100, 1'b1, 1'b0, 1'b0, 6'h00,          1'b0, 1'b1, 8'h33};
    tbl[6]  = '{1'b0, 1'b1, 5'h11, 8'h00, 5'h00, 10'd300, 10'd100, 1'b1, 1'b0, 1'b0, 6'h00,          1'b0, 1'b1, 8'h15};
    tbl[7]  = '{1'b1, 1'b0, 5'h05, 8'h16, 5'h05, 10'd300, 10'd100, 1'b1, 1'b0, 1'b1, 6'h2A,          1'b0, 1'b1, 8'h15};
    tbl[8]  = '{1'b0, 1'b0, 5'h00, 8'h00, 5'h05, 10'd10,  10'd20,  1'b1, 1'b0, 1'b1, 6'h16,          1'b1, 1'b0, 8'h00};
    tbl[9]  = '{1'b1, 1'b0, 5'h00, 8'h0F, 5'h00, 10'd300, 10'd100, 1'b1, 1'b0, 1'b0, 6'h00,          1'b0, 1'b0, 8'h00};
    tbl[10] = '{1'b1, 1'b0, 5'h14, 8'h30, 5'h00, 10'd300, 10'd100, 1'b1, 1'b0, 1'b0, 6'h00,          1'b0, 1'b0, 8'h00};
    tbl[11] = '{1'b0, 1'b0, 5'h00, 8'h00, 5'h14, 10'd10,  10'd20,  1'b1, 1'b0, 1'b1, 6'h0F,          1'b1, 1'b0, 8'h00};
    tbl[12] = '{1'b0, 1'b0, 5'h00, 8'h00, 5'h05, 10'd300, 10'd100, 1'b1, 1'b0, 1'b1, 6'h0F,          1'b0, 1'b0, 8'h00};
    tbl[13] = '{1'b0, 1'b0, 5'h00, 8'h00, 5'h05, 10'd10,  10'd20,  1'b0, 1'b0, 1'b1, 6'h0F,          1'b1, 1'b0, 8'h00};
    tbl[14] = '{1'b0, 1'b0, 5'h00, 8'h00, 5'h05, 10'd100, 10'd240, 1'b1, 1'b0, 1'b1, 6'h0F,          1'b0, 1'b0, 8'h00};
    tbl[15] = '{1'b0, 1'b0, 5'h00, 8'h00, 5'h05, 10'd255, 10'd239, 1'b1, 1'b0, 1'b1, 6'h16,          1'b1, 1'b0, 8'h00};
    tbl[16] = '{1'b1, 1'b0, 5'h07, 8'h01, 5'h05, 10'd256, 10'd0,   1'b1, 1'b0, 1'b1, 6'h0F,          1'b0, 1'b0, 8'h00};
    tbl[17] = '{1'b0, 1'b0, 5'h00, 8'h00, 5'h07, 10'd10,  10'd20,  1'b1, 1'b0, 1'b1, 6'h01,          1'b1, 1'b0, 8'h00};
    tbl[18] = '{1'b1, 1'b0, 5'h07, 8'h22, 5'h07, 10'd11,  10'd20,  1'b1, 1'b0, 1'b1, 6'h22,          1'b1, 1'b0, 8'h00};
    tbl[19] = '{1'b0, 1'b0, 5'h00, 8'h00, 5'h07, 10'd12,  10'd20,  1'b1, 1'b0, 1'b1, 6'h22,          1'b1, 1'b0, 8'h00};
    tbl[20] = '{1'b1, 1'b1, 5'h1C, 8'h3F, 5'h00, 10'd300, 10'd100, 1'b1, 1'b0, 1'b0, 6'h00,          1'b0, 1'b1, 8'h00};
    tbl[21] = '{1'b0, 1'b1, 5'h0C, 8'h00, 5'h00, 10'd300, 10'd100, 1'b1, 1'b0, 1'b0, 6'h00,          1'b0, 1'b1, 8'h3F};
    tbl[22] = '{1'b1, 1'b0, 5'h03, 8'h27, 5'h00, 10'd300, 10'd100, 1'b1, 1'b0, 1'b0, 6'h00,          1'b0, 1'b0, 8'h00};
    tbl[23] = '{1'b0, 1'b0, 5'h00, 8'h00, 5'h03, 10'd10,  10'd20,  1'b1, 1'b1, 1'b1, 6'h27 & GREY_M, 1'b1, 1'b0, 8'h00};
    tbl[24] = '{1'b0, 1'b1, 5'h03, 8'h00, 5'h03, 10'd11,  10'd20,  1'b1, 1'b1, 1'b0, 6'h00,          1'b0, 1'b1, 8'h27};
    tbl[25] = '{1'b0, 1'b0, 5'h00, 8'h00, 5'h03, 10'd12,  10'd20,  1'b1, 1'b0, 1'b1, 6'h27,          1'b1, 1'b0, 8'h00};

    // Reset state
    reset = 1'b1; idle();
    tick(); tick();
    check("rst_color_idx", color_idx, 6'h00);
    check("rst_color_valid", color_valid, 1'b0);
    check("rst_pal_data_out", pal_data_out, 8'h00);
    reset = 1'b0;

    // Table: CPU read data checks after its own edge, colour checks one edge later
    for (int i = 0; i <= NV; i++) begin
      if (i < NV) drive(tbl[i]); else idle();
      tick();
      if (i < NV && tbl[i].chk_d) check($sformatf("v%0d_pal_data_out", i), pal_data_out, tbl[i].exp_d);
      if (i > 0 && tbl[i-1].chk_c) begin
        check($sformatf("v%0d_color_idx", i-1), color_idx, tbl[i-1].exp_c);
        check($sformatf("v%0d_color_valid", i-1), color_valid, tbl[i-1].exp_v);
      end
    end

    // Scanline sweep: valid must cover exactly dots 0..255, two cycles late
    idle(); tick(); tick();
    first_v = -1; last_v = -1; cnt_v = 0;
    for (int k = 0; k < 345; k++) begin
      pixel = 5'h05; scanline = 10'd5; x_idx = (k < 341) ? 10'(k) : 10'd300;
      tick();
      if (color_valid) begin
        if (first_v < 0) first_v = k;
        last_v = k;
        cnt_v++;
      end
    end
    check("sweep_first_valid", first_v, 1);
    check("sweep_last_valid", last_v, 256);
    check("sweep_valid_count", cnt_v, 256);

    // Reset mid-frame clears pipeline and RAM
    pixel = 5'h05; x_idx = 10'd20; scanline = 10'd30;
    tick();
    reset = 1'b1; tick();
    check("midrst_color_idx", color_idx, 6'h00);
    check("midrst_color_valid", color_valid, 1'b0);
    check("midrst_pal_data_out", pal_data_out, 8'h00);
    reset = 1'b0; pal_re = 1'b1; pal_addr = 5'h05;
    tick();
    pal_re = 1'b0;
    check("postrst_valid_1cyc", color_valid, 1'b0);
    check("postrst_ram_cleared", pal_data_out, 8'h00);
    tick();
    check("postrst_valid_2cyc", color_valid, 1'b1);
    check("postrst_color_idx", color_idx, 6'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ppu_palette.md
# ppu_palette

Downstream stage of the PPU render pipeline. Takes the 5-bit palette address produced per dot by the render stage's sprite/background priority mux and resolves it through a 32-entry palette RAM into a 6-bit NES colour index for the video output stage. It also hosts the CPU-side palette window ($3F00–$3F1F via PPUDATA), including the hardware mirroring of the sprite backdrop entries.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock; one pixel dot per cycle
- reset  in  1  synchronous, active-high reset
- pixel  in  5  palette address from render stage; bit 4 = sprite palette, [3:2] = palette, [1:0] = colour
- x_idx  in  10  current dot index, same cycle as pixel
- scanline  in  10  current scanline, same cycle as pixel
- rendering_en  in  1  PPUMASK bg|spr enable; 0 forces backdrop
- greyscale  in  1  PPUMASK bit 0; honoured only with the macro
- pal_we  in  1  CPU write strobe, 1 cycle
- pal_re  in  1  CPU read strobe, 1 cycle
- pal_addr  in  5  CPU palette address (VRAM addr[4:0])
- pal_data_in  in  8  CPU write data; bits [7:6] ignored
- pal_data_out  out  8  CPU read data, {2'b00, entry}
- color_idx  out  6  NES master-palette index for the output stage
- color_valid  out  1  color_idx belongs to a visible dot

## Operation
- Storage: 32 × 6-bit registers. All entries clear to 0 on reset.
- Mirroring: the function m(a) applies to every access, CPU and render. If a[4]=1 and a[1:0]=0, m(a) = {1'b0, a[3:0]}. Otherwise m(a) = a. So 0x10/0x14/0x18/0x1C alias 0x00/0x04/0x08/0x0C.
- Transparency: if pixel[1:0]=0, the lookup address is 0x00, the universal backdrop. This applies to both sprite and background pixels.
- Visible region: x_idx < 256 and scanline < 240. Outside it, the lookup address is 0x00 and validity is 0.
- Rendering disabled (rendering_en=0): lookup address is 0x00 for every dot. Validity still follows the visible region.
- Pipeline:
  - S1 registers the effective lookup address and the visible flag.
  - S2 registers ram[S1 addr] into color_idx, and the visible flag into color_valid.
- CPU write: when pal_we=1, ram[m(pal_addr)] <= pal_data_in[5:0] at the clock edge.
- CPU read: when pal_re=1, pal_data_out <= {2'b00, ram[m(pal_addr)]}. The value is available the following cycle and is held until the next pal_re.
- Simultaneous pal_we and pal_re:
  - Same mirrored address: the read returns the old contents (read-before-write).
  - Different addresses: both operations complete.
- Collision between an S2 lookup and a CPU write to the same entry: S2 returns the old contents. The new value is seen from the next cycle onward.

## Timing
- Reset values: color_idx=0, color_valid=0, pal_data_out=0, S1 address=0, S1 visible flag=0.
- Reset asserted mid-frame: the pipeline and RAM clear on that edge. The first valid output appears 2 cycles after reset deasserts, and only for a visible dot.
- Latency: pixel/x_idx/scanline at cycle N produce color_idx/color_valid at cycle N+2. The throughput is one dot per cycle with no stalls.
- color_valid is high for exactly 256 consecutive cycles per visible scanline. It goes high 2 cycles after x_idx=0.
- A write at cycle N affects any lookup whose S2 stage is at cycle N+1 or later.

## Configuration
- PPU_PAL_GREYSCALE_EN defined:
  - When greyscale=1, color_idx is the S2 value AND 6'h30, applied in the S2 register.
  - pal_data_out is unaffected by greyscale.
- PPU_PAL_GREYSCALE_EN undefined:
  - The greyscale input is ignored.
  - color_idx is the raw RAM value.
  - No extra logic is generated.

## Test plan
- Mirroring: write 0x2A to address 0x10. A read of 0x00 returns 0x2A, and a read of 0x10 returns 0x2A. Write 0x15 to address 0x11; a read of 0x01 returns its prior value, unchanged.
- Lookup latency: load ram[0x05]=0x16. Drive pixel=0x05 at x_idx=10, scanline=20. color_idx=0x16 and color_valid=1 exactly 2 cycles later.
- Transparency and backdrop: load ram[0x00]=0x0F and ram[0x14]=0x30. Drive pixel=0x14 on a visible dot. color_idx=0x0F, because 0x14 both mirrors and has low bits 0.
- Blanking: drive x_idx=300, scanline=100, pixel=0x05. color_valid=0 and color_idx=ram[0x00]. Then drive rendering_en=0 on a visible dot with pixel=0x05. color_idx=ram[0x00] and color_valid=1.
- Write/lookup collision: ram[0x07]=0x01. In the same cycle that S2 reads entry 0x07, write 0x22 to it. That output is 0x01, and the next dot with pixel=0x07 yields 0x22.
- Greyscale (macro defined): ram[0x03]=0x27 and greyscale=1. Lookup yields color_idx=0x20, while a CPU read returns 0x27. With the macro undefined, the same stimulus yields 0x27.
